sdram_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port SDRAM controller between `NUM_PORTS` requesters, such as the CPU fetch path, the data path and video/DMA. It accepts one request at a time on a valid/ready interface and drives the controller's `enable`/`ready` handshake. It returns read data, or write completion, to the owning port as a one-cycle response pulse. It sits between the requesters and the SDRAM controller, in the controller's `clk` domain.

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/sdram_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared widths, FSM state type and data width codes for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WIDTH_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Width codes travel untouched to the controller; 2 and 3 both mean a full word.
    localparam logic [WIDTH_W-1:0] WIDTH_BYTE  = 2'd0;
    localparam logic [WIDTH_W-1:0] WIDTH_HALF  = 2'd1;
    localparam logic [WIDTH_W-1:0] WIDTH_WORD  = 2'd2;
    localparam logic [WIDTH_W-1:0] WIDTH_WORD3 = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after i_last, wrapping.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req_valid,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int unsigned w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        // k = N revisits i_last itself, so a lone requester is still served.
        for (int unsigned k = 1; k <= N; k++) begin
            w_j = (32'(i_last) + k) % N;
            if (!o_any && i_req_valid[IDX_W'(w_j)]) begin
                o_any                  = 1'b1;
                o_idx                  = IDX_W'(w_j);
                o_grant[IDX_W'(w_j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NUM_PORTS requesters,
// driving the controller enable/ready handshake and returning one-cycle responses.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_PORTS-1:0]          i_req_valid,
    output logic [NUM_PORTS-1:0]          o_req_ready,
    input  logic [ADDR_W*NUM_PORTS-1:0]   i_req_addr,
    input  logic [NUM_PORTS-1:0]          i_req_write,
    input  logic [DATA_W*NUM_PORTS-1:0]   i_req_wdata,
    input  logic [WIDTH_W*NUM_PORTS-1:0]  i_req_width,
    output logic [NUM_PORTS-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]             o_rsp_rdata,
    output logic                          o_mem_enable,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic                          o_mem_write,
    output logic [DATA_W-1:0]             o_mem_wdata,
    output logic [WIDTH_W-1:0]            o_mem_width,
    input  logic [DATA_W-1:0]             i_mem_read_data,
    input  logic                          i_mem_ready,
    output logic                          o_err
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1) + 1;

    arb_state_e             r_state;
    logic [IDX_W-1:0]       r_last;
    logic [IDX_W-1:0]       r_owner;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_err;
    logic                   r_mem_enable;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic                   r_mem_write;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic [WIDTH_W-1:0]     r_mem_width;
    logic [NUM_PORTS-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]      r_rsp_rdata;

    logic [NUM_PORTS-1:0]   w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_can_grant;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic                   w_sel_write;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic [WIDTH_W-1:0]     w_sel_width;

    rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req_valid (i_req_valid),
        .i_last      (r_last),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    // Controller init holds ready low, which keeps every port blocked here.
    assign w_can_grant = (r_state == IDLE) && i_mem_ready;
    assign o_req_ready = w_can_grant ? w_grant : '0;

    assign w_sel_addr  = i_req_addr[ADDR_W*w_idx +: ADDR_W];
    assign w_sel_write = i_req_write[w_idx];
    assign w_sel_wdata = i_req_wdata[DATA_W*w_idx +: DATA_W];
    assign w_sel_width = i_req_width[WIDTH_W*w_idx +: WIDTH_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_last       <= IDX_W'(NUM_PORTS - 1);
            r_owner      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_width  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            r_rsp_valid <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_can_grant && w_any) begin
                        r_mem_addr   <= w_sel_addr;
                        r_mem_write  <= w_sel_write;
                        r_mem_wdata  <= w_sel_wdata;
                        r_mem_width  <= w_sel_width;
                        r_mem_enable <= 1'b1;
                        r_owner      <= w_idx;
                        r_last       <= w_idx;
                        r_cnt        <= '0;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Refresh can stretch ISSUE legally; err only flags, never aborts.
                    if (32'(r_cnt) < TIMEOUT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (32'(r_cnt) + 32'd1 >= TIMEOUT) begin
                        r_err <= 1'b1;
                    end
                    if (!i_mem_ready) begin
                        r_mem_enable <= 1'b0;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_ready) begin
                        r_rsp_rdata <= i_mem_read_data;
                        r_rsp_valid <= NUM_PORTS'(1) << r_owner;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_mem_enable = r_mem_enable;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_write  = r_mem_write;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_width  = r_mem_width;
    assign o_err        = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller plus a round-robin reference model.
module tb_sdram_arbiter;

    localparam int NP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [24*NP-1:0]  req_addr;
    logic [32*NP-1:0]  req_wdata;
    logic [2*NP-1:0]   req_width;
    logic [31:0]       rsp_rdata, mem_wdata, mem_read_data;
    logic              mem_enable, mem_write, mem_ready, err;
    logic [23:0]       mem_addr;
    logic [1:0]        mem_width;

    sdram_arbiter #(.NUM_PORTS(NP), .TIMEOUT(255)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_addr(req_addr), .i_req_write(req_write),
        .i_req_wdata(req_wdata), .i_req_width(req_width),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_mem_enable(mem_enable), .o_mem_addr(mem_addr), .o_mem_write(mem_write),
        .o_mem_wdata(mem_wdata), .o_mem_width(mem_width),
        .i_mem_read_data(mem_read_data), .i_mem_ready(mem_ready), .o_err(err)
    );

    // Second instance: controller that never captures, for the timeout flag.
    logic              t_rst, t_mready, t_en, t_mw, t_err;
    logic [NP-1:0]     t_valid, t_ready, t_rsp;
    logic [31:0]       t_rdata, t_mwd;
    logic [23:0]       t_ma;
    logic [1:0]        t_mwid;

    sdram_arbiter #(.NUM_PORTS(NP), .TIMEOUT(8)) dut_to (
        .i_clk(clk), .i_rst(t_rst),
        .i_req_valid(t_valid), .o_req_ready(t_ready),
        .i_req_addr('0), .i_req_write('0),
        .i_req_wdata('0), .i_req_width('0),
        .o_rsp_valid(t_rsp), .o_rsp_rdata(t_rdata),
        .o_mem_enable(t_en), .o_mem_addr(t_ma), .o_mem_write(t_mw),
        .o_mem_wdata(t_mwd), .o_mem_width(t_mwid),
        .i_mem_read_data(32'h0), .i_mem_ready(t_mready), .o_err(t_err)
    );

    // Controller model: init holds ready low, refresh keeps ready high before capture,
    // ready falls one cycle after capture and rises again with the result.
    logic        m_hold_init;
    int          m_ref_len, m_lat;
    int          m_st, m_cnt;
    logic [23:0] m_a;
    logic        m_w;
    logic [31:0] m_wd;
    logic [31:0] m_mem [1024];
    bit          m_vld [1024];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready     <= 1'b0;
            mem_read_data <= 32'h0;
            m_st          <= 0;
            m_cnt         <= 0;
        end else if (m_hold_init) begin
            mem_ready <= 1'b0;
            m_st      <= 0;
        end else begin
            case (m_st)
                0: begin
                    mem_ready <= 1'b1;
                    if (mem_enable && mem_ready) begin
                        if (m_ref_len > 0) begin
                            m_st  <= 1;
                            m_cnt <= m_ref_len - 1;
                        end else begin
                            m_a <= mem_addr; m_w <= mem_write; m_wd <= mem_wdata;
                            m_st <= 2;
                        end
                    end
                end
                1: begin
                    if (m_cnt == 0) begin
                        m_a <= mem_addr; m_w <= mem_write; m_wd <= mem_wdata;
                        m_st <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                2: begin
                    mem_ready <= 1'b0;
                    m_cnt     <= m_lat;
                    m_st      <= 3;
                    if (m_w) begin
                        m_mem[m_a[9:0]] <= m_wd;
                        m_vld[m_a[9:0]] <= 1'b1;
                        mem_read_data   <= {8'hA5, m_a};
                    end else begin
                        mem_read_data <= m_vld[m_a[9:0]] ? m_mem[m_a[9:0]] : {8'h5A, m_a};
                    end
                end
                default: begin
                    if (m_cnt == 0) begin
                        mem_ready <= 1'b1;
                        m_st      <= 0;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            endcase
        end
    end

    // Requester state and reference model.
    bit          p_pend [NP];
    logic [23:0] p_addr [NP];
    logic        p_write [NP];
    logic [31:0] p_wdata [NP];
    logic [1:0]  p_width [NP];
    int          p_wait [NP];

    bit          ex_busy, ex_en;
    int          ex_owner, ex_last, ex_busy_cyc;
    logic [31:0] ex_rdata;
    logic [31:0] ref_mem [logic [23:0]];
    int          grants [$];
    int          n_grant, n_rsp, rsp_hits, en_cycles, rdy_cycles;
    int          ready_hi [NP];
    logic [NP-1:0] last_rsp_vec;
    logic [31:0]   last_rsp_data;
    bit          s_mrdy, s_grant;
    int          n_chk, n_pass, n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {8'h5A, a};
    endfunction

    function automatic bit any_pend();
        bit r = 0;
        for (int i = 0; i < NP; i++) r |= p_pend[i];
        return r;
    endfunction

    task automatic new_req(input int p, input logic [23:0] a, input logic w,
                           input logic [31:0] d, input logic [1:0] wd);
        p_pend[p] = 1; p_addr[p] = a; p_write[p] = w; p_wdata[p] = d; p_width[p] = wd;
    endtask

    task automatic new_rand(input int p);
        new_req(p, 24'($urandom_range(0, 31)) << 2, 1'($urandom_range(0, 1)), $urandom,
                2'($urandom_range(0, 3)));
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            req_valid[i]          = p_pend[i];
            req_addr[24*i +: 24]  = p_addr[i];
            req_write[i]          = p_write[i];
            req_wdata[32*i +: 32] = p_wdata[i];
            req_width[2*i +: 2]   = p_width[i];
        end
    endtask

    task automatic clear_counts();
        rsp_hits = 0; en_cycles = 0; rdy_cycles = 0;
        for (int i = 0; i < NP; i++) ready_hi[i] = 0;
    endtask

    // One clock: drive, check mid-cycle, then account for what the edge accepted.
    task automatic tick();
        int g;
        logic [31:0] exp_rdy;
        logic rdy_s;
        drive();
        @(negedge clk);
        if (rsp_valid !== '0) begin
            check("rsp_port", 32'(rsp_valid), ex_busy ? (32'd1 << ex_owner) : 32'd0);
            check("rsp_rdata", rsp_rdata, ex_rdata);
            ex_busy = 0; n_rsp++; rsp_hits++;
            last_rsp_vec = rsp_valid; last_rsp_data = rsp_rdata;
        end
        check("mem_enable", 32'(mem_enable), 32'(ex_en));
        g = -1;
        if (!ex_busy && mem_ready === 1'b1) begin
            for (int k = 1; k <= NP; k++) begin
                int j = (ex_last + k) % NP;
                if (g < 0 && p_pend[j]) g = j;
            end
        end
        exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
        check("req_ready", 32'(req_ready), exp_rdy);
        for (int i = 0; i < NP; i++) if (req_ready[i] === 1'b1) ready_hi[i]++;
        if (req_ready !== '0) rdy_cycles++;
        if (mem_enable === 1'b1) en_cycles++;
        rdy_s = mem_ready;
        s_mrdy = (mem_ready === 1'b1);
        s_grant = (g >= 0);
        if (ex_busy) begin
            ex_busy_cyc++;
            if (ex_busy_cyc > 400) begin
                check("rsp_timeout", 32'(ex_busy_cyc), 32'd400);
                ex_busy = 0;
            end
        end
        @(posedge clk);
        #1;
        if (ex_en && rdy_s === 1'b0) ex_en = 0;
        if (g >= 0) begin
            grants.push_back(g); n_grant++;
            check("wait_bound", 32'(p_wait[g] <= NP - 1), 32'd1);
            for (int i = 0; i < NP; i++) if (i != g && p_pend[i]) p_wait[i]++;
            p_wait[g] = 0;
            check("mem_addr", 32'(mem_addr), 32'(p_addr[g]));
            check("mem_write", 32'(mem_write), 32'(p_write[g]));
            check("mem_wdata", mem_wdata, p_wdata[g]);
            check("mem_width", 32'(mem_width), 32'(p_width[g]));
            ex_rdata = p_write[g] ? {8'hA5, p_addr[g]} : ref_rd(p_addr[g]);
            if (p_write[g]) ref_mem[p_addr[g]] = p_wdata[g];
            ex_busy = 1; ex_en = 1; ex_owner = g; ex_last = g; ex_busy_cyc = 0;
            p_pend[g] = 0;
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((ex_busy || any_pend()) && t < 600) begin
            tick(); t++;
        end
        tick();
        check(tag, 32'(ex_busy || any_pend()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) begin p_pend[i] = 0; p_wait[i] = 0; end
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ex_busy = 0; ex_en = 0; ex_last = NP - 1; ex_busy_cyc = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rdy_t, grant_t;
        n_chk = 0; n_pass = 0; n_fail = 0; n_grant = 0; n_rsp = 0;
        rst = 1'b1; t_rst = 1'b1; t_valid = '0; t_mready = 1'b1;
        m_hold_init = 1'b1; m_ref_len = 0; m_lat = 2;
        for (int i = 0; i < NP; i++) new_req(i, 24'h0, 1'b0, 32'h0, 2'd0);
        for (int i = 0; i < NP; i++) p_pend[i] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Controller init: port 0 waits 100 cycles with ready low.
        do_reset();
        clear_counts();
        new_req(0, 24'h000010, 1'b0, 32'h0, 2'd2);
        repeat (100) tick();
        check("init_no_ready", 32'(rdy_cycles), 32'd0);
        check("init_no_enable", 32'(en_cycles), 32'd0);
        m_hold_init = 1'b0;
        rdy_t = -1; grant_t = -2;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (s_mrdy && rdy_t < 0) rdy_t = t;
            if (s_grant) begin grant_t = t; break; end
        end
        check("init_grant_cycle", 32'(grant_t), 32'(rdy_t));
        drain("init_drain");

        // Single read on port 1 after seeding the location through port 2.
        new_req(2, 24'h000200, 1'b1, 32'hDEADBEEF, 2'd2);
        drain("seed_drain");
        clear_counts();
        new_req(1, 24'h000200, 1'b0, 32'h0, 2'd2);
        drain("read_drain");
        repeat (3) tick();
        check("read_ready_cycles", 32'(ready_hi[1]), 32'd1);
        check("read_rsp_count", 32'(rsp_hits), 32'd1);
        check("read_rsp_vec", 32'(last_rsp_vec), 32'h2);
        check("read_rsp_data", last_rsp_data, 32'hDEADBEEF);
        check("read_enable_min", 32'(en_cycles >= 2), 32'd1);

        // Continuous requests from all ports after reset: strict rotation from port 0.
        do_reset();
        grants.delete();
        for (int t = 0; t < 600 && grants.size() < 9; t++) begin
            for (int i = 0; i < NP; i++) if (!p_pend[i]) new_rand(i);
            tick();
        end
        drain("rot_drain");
        check("rot_count", 32'(grants.size() >= 9), 32'd1);
        for (int i = 0; i < 9 && i < grants.size(); i++) begin
            check($sformatf("rot_order_%0d", i), 32'(grants[i]), 32'(i % NP));
        end

        // Refresh with ready held high while enable is asserted.
        clear_counts();
        m_ref_len = 7;
        new_req(0, 24'h000040, 1'b0, 32'h0, 2'd1);
        drain("refresh_drain");
        repeat (3) tick();
        m_ref_len = 0;
        check("refresh_enable_len", 32'(en_cycles >= 8), 32'd1);
        check("refresh_rsp_count", 32'(rsp_hits), 32'd1);
        check("refresh_err", 32'(err), 32'd0);

        // Randomised traffic, latency and occasional refresh.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NP; i++) if (!p_pend[i] && $urandom_range(0, 3) == 0) new_rand(i);
            m_lat = $urandom_range(0, 4);
            m_ref_len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
            tick();
        end
        m_ref_len = 0; m_lat = 2;
        drain("rand_drain");
        check("rand_rsp_total", 32'(n_rsp), 32'(n_grant));
        check("rand_err", 32'(err), 32'd0);

        // Reset while waiting for the controller.
        m_lat = 30;
        new_req(2, 24'h000123, 1'b0, 32'h0, 2'd3);
        for (int t = 0; t < 50 && !(ex_busy && !ex_en); t++) tick();
        check("wait_reached", 32'(ex_busy && !ex_en), 32'd1);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_rdata", rsp_rdata, 32'd0);
        check("arst_mem_enable", 32'(mem_enable), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_width", 32'(mem_width), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        do_reset();
        m_lat = 2;
        grants.delete();
        new_req(2, 24'h000008, 1'b0, 32'h0, 2'd0);
        new_req(1, 24'h00000C, 1'b0, 32'h0, 2'd0);
        new_req(0, 24'h000004, 1'b0, 32'h0, 2'd0);
        for (int t = 0; t < 20 && grants.size() == 0; t++) tick();
        check("post_rst_first", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
        drain("post_rst_drain");

        // Timeout: controller never drops ready, err rises after 8 ISSUE cycles.
        t_valid = 3'b001;
        @(negedge clk);
        t_rst = 1'b0;
        for (int t = 0; t < 10 && t_ready !== 3'b001; t++) @(negedge clk);
        check("to_ready", 32'(t_ready), 32'h1);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("to_err_%0d", k), 32'(t_err), 32'(k >= 8));
        end
        t_valid = '0;
        repeat (20) @(posedge clk);
        #1;
        check("to_err_sticky", 32'(t_err), 32'd1);
        check("to_no_abort", 32'(t_en), 32'd1);
        t_rst = 1'b1;
        #1;
        check("to_err_rst", 32'(t_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
